// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates one instruction fetch and one load/store and
// serializes them onto the 8-bit RAM/IO bus, returning little-endian words.
module mem_responder #(
    parameter logic [31:0] IO_BASE = 32'h30000,
    parameter int          ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              io_buffer_full,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_clr,
    output logic              inst_flag,
    output logic [31:0]       inst_out,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_len,
    input  logic              data_signed,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_flag,
    output logic [31:0]       data_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] IO_MASK = IO_BASE[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] mem_a_r;
    logic [7:0]        mem_dout_r;
    logic              wr_en_r;
    logic [31:0]       wdata_r;
    logic [1:0]        last_r;
    logic              sgn_r;
    logic              fetch_r;
    logic [1:0]        cnt_r;
    logic [2:0]        iss_r;
    logic              pv_r;
    logic [31:0]       bytes_r;
    logic              inst_flag_r;
    logic              data_flag_r;
    logic [31:0]       inst_out_r;
    logic [31:0]       data_rdata_r;

    logic              io_s;
    logic              io_stall_s;
    logic [31:0]       cap_word_s;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] last,
                                           input logic sgn);
        case (last)
            2'd0:    return {{24{sgn & w[7]}}, w[7:0]};
            2'd1:    return {{16{sgn & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [1:0] len_to_last(input logic [1:0] len);
        case (len)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // I/O decode of the address on the bus and the uart back-pressure it implies
    always_comb begin
        io_s       = ((mem_a_r & IO_MASK) == IO_MASK);
        io_stall_s = io_s & io_buffer_full;
    end

    // Current byte lanes with the incoming byte merged into the lane being captured
    always_comb begin
        cap_word_s = bytes_r;
        cap_word_s[{cnt_r, 3'b000} +: 8] = mem_din;
    end

    // Main sequencer: arbitration, address issue, byte capture and result registration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            base_r       <= '0;
            mem_a_r      <= '0;
            mem_dout_r   <= 8'h00;
            wr_en_r      <= 1'b0;
            wdata_r      <= 32'h0;
            last_r       <= 2'd0;
            sgn_r        <= 1'b0;
            fetch_r      <= 1'b0;
            cnt_r        <= 2'd0;
            iss_r        <= 3'd0;
            pv_r         <= 1'b0;
            bytes_r      <= 32'h0;
            inst_flag_r  <= 1'b0;
            data_flag_r  <= 1'b0;
            inst_out_r   <= 32'h0;
            data_rdata_r <= 32'h0;
        end else if (!rdy) begin
            // Any byte still in flight is dropped; the read path re-issues it on resume
            pv_r <= 1'b0;
        end else begin
            inst_flag_r <= 1'b0;
            data_flag_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    cnt_r <= 2'd0;
                    iss_r <= 3'd0;
                    pv_r  <= 1'b0;
                    if (data_req) begin
                        fetch_r <= 1'b0;
                        base_r  <= data_addr;
                        mem_a_r <= data_addr;
                        last_r  <= len_to_last(data_len);
                        sgn_r   <= data_signed;
                        wdata_r <= data_wdata;
                        wr_en_r <= data_wr;
                        if (data_wr) begin
                            mem_dout_r <= data_wdata[7:0];
                            state_r    <= S_WRITE;
                        end else begin
                            state_r    <= S_READ;
                        end
                    end else if (inst_req && !inst_clr) begin
                        fetch_r <= 1'b1;
                        base_r  <= inst_addr;
                        mem_a_r <= inst_addr;
                        last_r  <= 2'd3;
                        sgn_r   <= 1'b0;
                        wr_en_r <= 1'b0;
                        state_r <= S_READ;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (fetch_r && inst_clr) begin
                        pv_r    <= 1'b0;
                        state_r <= S_IDLE;
                    end else if (!pv_r && iss_r != {1'b0, cnt_r}) begin
                        // Resuming after a freeze lost a byte: rewind to the first uncaptured one
                        mem_a_r <= base_r + {{(ADDR_W-2){1'b0}}, cnt_r};
                        iss_r   <= {1'b0, cnt_r};
                    end else begin
                        if (pv_r) begin
                            bytes_r <= cap_word_s;
                            cnt_r   <= cnt_r + 2'd1;
                            if (cnt_r == last_r) begin
                                state_r <= S_DONE;
                                if (fetch_r) begin
                                    inst_flag_r <= 1'b1;
                                    inst_out_r  <= cap_word_s;
                                end else begin
                                    data_flag_r  <= 1'b1;
                                    data_rdata_r <= extend(cap_word_s, last_r, sgn_r);
                                end
                            end
                        end
                        if (iss_r <= {1'b0, last_r}) begin
                            pv_r  <= 1'b1;
                            iss_r <= iss_r + 3'd1;
                            if (iss_r != {1'b0, last_r}) begin
                                mem_a_r <= mem_a_r + A_ONE;
                            end
                        end else begin
                            pv_r <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    if (!io_stall_s) begin
                        if (cnt_r == last_r) begin
                            wr_en_r     <= 1'b0;
                            data_flag_r <= 1'b1;
                            state_r     <= S_DONE;
                        end else begin
                            cnt_r      <= cnt_r + 2'd1;
                            mem_a_r    <= mem_a_r + A_ONE;
                            mem_dout_r <= byte_of(wdata_r, cnt_r + 2'd1);
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_a      = mem_a_r;
    assign mem_dout   = mem_dout_r;
    assign mem_wr     = wr_en_r & rdy & ~io_stall_s;
    assign inst_flag  = inst_flag_r & rdy & ~inst_clr;
    assign data_flag  = data_flag_r & rdy;
    assign inst_out   = inst_out_r;
    assign data_rdata = data_rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a byte RAM with one cycle of read latency,
// an I/O write log, and one task per scenario with inline checks.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_clr;
    logic        inst_flag;
    logic [31:0] inst_out;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_len;
    logic        data_signed;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_flag;
    logic [31:0] data_rdata;

    int n_tests;
    int n_fail;

    logic [7:0]  ram  [0:4095];
    logic [7:0]  wram [0:4095];
    logic [7:0]  io_b [0:15];
    logic [31:0] io_a [0:15];
    int          io_n;

    mem_responder dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_clr(inst_clr),
        .inst_flag(inst_flag), .inst_out(inst_out),
        .data_req(data_req), .data_wr(data_wr), .data_len(data_len),
        .data_signed(data_signed), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_flag(data_flag), .data_rdata(data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, writes split into RAM and I/O log
    initial io_n = 0;
    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            if (mem_a[17:16] == 2'b11) begin
                io_b[io_n[3:0]] <= mem_dout;
                io_a[io_n[3:0]] <= mem_a;
                io_n <= io_n + 1;
            end else begin
                wram[mem_a[11:0]] <= mem_dout;
            end
        end
    end

    // Counts negedges until the selected flag is seen (-1 if never); optional flush at clr_at
    task automatic wait_flag(input bit sel, input int budget, input int clr_at, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == clr_at) begin
                inst_clr = 1'b1;
                inst_req = 1'b0;
            end
            #1;
            if (sel ? data_flag : inst_flag) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic start_data(input bit wr, input logic [1:0] len, input bit sgn,
                              input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        data_wr = wr; data_len = len; data_signed = sgn; data_addr = addr; data_wdata = wd;
        data_req = 1'b1;
    endtask

    task automatic start_fetch(input logic [31:0] addr);
        @(negedge clk);
        inst_addr = addr;
        inst_req  = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if ({mem_a, mem_dout, mem_wr, inst_flag, data_flag} !== 43'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got a=%h dout=%h wr=%b if=%b df=%b want all 0",
                     mem_a, mem_dout, mem_wr, inst_flag, data_flag);
        end
        n_tests++;
        if ({inst_out, data_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_results: got inst_out=%h data_rdata=%h want 0", inst_out, data_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch;
        logic [31:0] a_seen [0:3];
        int n;
        n = -1;
        start_fetch(32'h100);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            #1;
            if (i <= 4) a_seen[i-1] = mem_a;
            if (inst_flag) begin
                n = i;
                break;
            end
        end
        inst_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (a_seen[k] !== 32'h100 + k) begin
                n_fail++;
                $display("FAIL fetch_addr%0d: got %h want %h", k, a_seen[k], 32'h100 + k);
            end
        end
        n_tests++;
        if (n !== 6) begin
            n_fail++;
            $display("FAIL fetch_latency: got %0d want 6", n);
        end
        n_tests++;
        if (inst_out !== 32'h00A00513) begin
            n_fail++;
            $display("FAIL fetch_data: got %h want 00a00513", inst_out);
        end
        @(negedge clk);
    endtask

    task automatic test_priority;
        int n;
        @(negedge clk);
        inst_addr = 32'h100; inst_req = 1'b1;
        data_wr = 1'b0; data_len = 2'd3; data_signed = 1'b0; data_addr = 32'h200; data_req = 1'b1;
        wait_flag(1'b1, 12, 0, n);
        data_req = 1'b0;
        n_tests++;
        if (n !== 6 || inst_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_data_first: got n=%0d inst_flag=%b want 6/0", n, inst_flag);
        end
        n_tests++;
        if (data_rdata !== 32'h44332211) begin
            n_fail++;
            $display("FAIL prio_data: got %h want 44332211", data_rdata);
        end
        wait_flag(1'b0, 12, 0, n);
        inst_req = 1'b0;
        n_tests++;
        if (n !== 7 || inst_out !== 32'h00A00513) begin
            n_fail++;
            $display("FAIL prio_inst_after: got n=%0d out=%h want 7/00a00513", n, inst_out);
        end
        @(negedge clk);
    endtask

    task automatic test_loads;
        int n;
        logic [1:0]  lens [0:3];
        logic        sgns [0:3];
        logic [31:0] adrs [0:3];
        logic [31:0] exps [0:3];
        int          lats [0:3];
        lens = '{2'd0, 2'd0, 2'd1, 2'd2};
        sgns = '{1'b1, 1'b0, 1'b1, 1'b0};
        adrs = '{32'h10, 32'h10, 32'h12, 32'h200};
        exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9234, 32'h44332211};
        lats = '{3, 3, 4, 6};
        for (int t = 0; t < 4; t++) begin
            start_data(1'b0, lens[t], sgns[t], adrs[t], 32'h0);
            wait_flag(1'b1, 12, 0, n);
            data_req = 1'b0;
            n_tests++;
            if (n !== lats[t] || data_rdata !== exps[t]) begin
                n_fail++;
                $display("FAIL load%0d: got n=%0d data=%h want n=%0d data=%h",
                         t, n, data_rdata, lats[t], exps[t]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store;
        int n;
        start_data(1'b1, 2'd3, 1'b0, 32'h40, 32'hDDCCBBAA);
        wait_flag(1'b1, 12, 0, n);
        data_req = 1'b0;
        n_tests++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL store_latency: got %0d want 5", n);
        end
        n_tests++;
        if ({wram[12'h43], wram[12'h42], wram[12'h41], wram[12'h40]} !== 32'hDDCCBBAA) begin
            n_fail++;
            $display("FAIL store_data: got %h want ddccbbaa",
                     {wram[12'h43], wram[12'h42], wram[12'h41], wram[12'h40]});
        end
        @(negedge clk);
    endtask

    task automatic test_io_stall;
        int n;
        int lows;
        int io0;
        n = -1; lows = 0; io0 = io_n;
        start_data(1'b1, 2'd1, 1'b0, 32'h30000, 32'h1234BEEF);
        io_buffer_full = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 4) io_buffer_full = 1'b0;
            #1;
            if (i <= 3 && mem_wr === 1'b0) lows++;
            if (data_flag) begin
                n = i;
                break;
            end
        end
        data_req = 1'b0;
        n_tests++;
        if (lows !== 3 || n !== 6) begin
            n_fail++;
            $display("FAIL io_stall: got lows=%0d n=%0d want 3/6", lows, n);
        end
        n_tests++;
        if (io_n - io0 !== 2 || io_b[io0[3:0]] !== 8'hEF || io_b[io0[3:0] + 4'd1] !== 8'hBE ||
            io_a[io0[3:0]] !== 32'h30000 || io_a[io0[3:0] + 4'd1] !== 32'h30001) begin
            n_fail++;
            $display("FAIL io_bytes: got n=%0d b0=%h b1=%h a0=%h want 2/ef/be/30000",
                     io_n - io0, io_b[io0[3:0]], io_b[io0[3:0] + 4'd1], io_a[io0[3:0]]);
        end
        @(negedge clk);
    endtask

    task automatic test_clr;
        int n;
        start_fetch(32'h100);
        wait_flag(1'b0, 10, 3, n);
        inst_clr = 1'b0;
        n_tests++;
        if (n !== -1 || inst_out !== 32'h00A00513) begin
            n_fail++;
            $display("FAIL clr_read: got n=%0d out=%h want -1/00a00513", n, inst_out);
        end
        start_fetch(32'h0);
        wait_flag(1'b0, 12, 0, n);
        inst_req = 1'b0;
        n_tests++;
        if (n !== 6 || inst_out !== 32'h00100093) begin
            n_fail++;
            $display("FAIL clr_refetch: got n=%0d out=%h want 6/00100093", n, inst_out);
        end
        @(negedge clk);
        start_fetch(32'h0);
        wait_flag(1'b0, 10, 6, n);
        inst_clr = 1'b0;
        n_tests++;
        if (n !== -1) begin
            n_fail++;
            $display("FAIL clr_done: got n=%0d want -1", n);
        end
        @(negedge clk);
    endtask

    task automatic test_rdy;
        int n;
        logic [31:0] a_frz;
        logic        w_frz;
        n = -1;
        start_fetch(32'h100);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) rdy = 1'b0;
            if (i == 5) rdy = 1'b1;
            #1;
            if (i == 3) begin
                a_frz = mem_a;
                w_frz = mem_wr;
            end
            if (inst_flag) begin
                n = i;
                break;
            end
        end
        inst_req = 1'b0;
        n_tests++;
        if (a_frz !== 32'h100 || w_frz !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_hold: got a=%h wr=%b want 100/0", a_frz, w_frz);
        end
        n_tests++;
        if (n !== 10 || inst_out !== 32'h00A00513) begin
            n_fail++;
            $display("FAIL rdy_delay: got n=%0d out=%h want 10/00a00513", n, inst_out);
        end
        @(negedge clk);
        // Freeze while a byte is in flight: it must be re-read, so the word stays intact
        n = -1;
        start_data(1'b0, 2'd3, 1'b0, 32'h200, 32'h0);
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == 3) rdy = 1'b0;
            if (i == 7) rdy = 1'b1;
            #1;
            if (data_flag) begin
                n = i;
                break;
            end
        end
        data_req = 1'b0;
        n_tests++;
        if (n < 10 || data_rdata !== 32'h44332211) begin
            n_fail++;
            $display("FAIL rdy_inflight: got n=%0d data=%h want >=10/44332211", n, data_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid_write;
        start_data(1'b1, 2'd3, 1'b0, 32'h44, 32'h11223344);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({mem_a, mem_dout, mem_wr, inst_flag, data_flag, inst_out, data_rdata} !== 107'h0) begin
            n_fail++;
            $display("FAIL rst_mid_write: got a=%h dout=%h wr=%b out=%h rd=%h want all 0",
                     mem_a, mem_dout, mem_wr, inst_out, data_rdata);
        end
        data_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        {ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]} = {8'h13, 8'h05, 8'hA0, 8'h00};
        {ram[12'h200], ram[12'h201], ram[12'h202], ram[12'h203]} = {8'h11, 8'h22, 8'h33, 8'h44};
        {ram[12'h000], ram[12'h001], ram[12'h002], ram[12'h003]} = {8'h93, 8'h00, 8'h10, 8'h00};
        ram[12'h010] = 8'h80;
        ram[12'h012] = 8'h34;
        ram[12'h013] = 8'h92;
        rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
        inst_req = 1'b0; inst_addr = 32'h0; inst_clr = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_len = 2'd0; data_signed = 1'b0;
        data_addr = 32'h0; data_wdata = 32'h0;

        test_reset();
        test_fetch();
        test_priority();
        test_loads();
        test_store();
        test_io_stall();
        test_clr();
        test_rdy();
        test_rst_mid_write();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
